// File: rtl/chan_mux_scan.sv
// rtl/chan_mux_scan.sv - registered N-channel mux with direct select or round-robin auto-scan
module chan_mux_scan #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [SELW-1:0]        sel,
    input  logic                   mode,
    input  logic                   en,
    output logic [WIDTH-1:0]       dout,
    output logic [SELW-1:0]        dout_ch,
    output logic                   dout_valid,
    output logic                   scan_wrap
);

    localparam int CW = 8;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t            state;
    logic [SELW-1:0]   ptr;
    logic [CW-1:0]     cnt;
    logic              wrap_pend;

    logic [NCH*WIDTH-1:0] dir_shift;
    logic [NCH*WIDTH-1:0] scan_shift;
    logic [WIDTH-1:0]     dir_data;
    logic [WIDTH-1:0]     scan_data;
    logic                 sel_ok;
    logic                 ptr_last;
    logic                 dwell_done;
    logic [SELW-1:0]      ptr_next;

    // Shifting past the end of the bus yields zero, which covers sel >= NCH.
    always_comb begin
        dir_shift  = din >> (32'(sel) * WIDTH);
        scan_shift = din >> (32'(ptr) * WIDTH);
        dir_data   = dir_shift[WIDTH-1:0];
        scan_data  = scan_shift[WIDTH-1:0];
        sel_ok     = (32'(sel) < NCH);
        ptr_last   = (ptr == SELW'(NCH - 1));
        dwell_done = (cnt == CW'(DWELL - 1));
        ptr_next   = ptr_last ? '0 : ptr + SELW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            wrap_pend  <= 1'b0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            scan_wrap  <= 1'b0;
        end else if (!en) begin
            dout_valid <= 1'b0;
            scan_wrap  <= 1'b0;
        end else if (!mode) begin
            state     <= DIRECT;
            cnt       <= '0;
            wrap_pend <= 1'b0;
            scan_wrap <= 1'b0;
            dout_ch   <= sel;
            if (sel_ok) begin
                ptr        <= sel;
                dout       <= dir_data;
                dout_valid <= 1'b1;
            end else begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end
        end else begin
            // The pointer advances after its last dwell edge, so the wrap is
            // flagged here and reported on the edge that first shows channel 0.
            state      <= SCAN;
            dout       <= scan_data;
            dout_ch    <= ptr;
            dout_valid <= 1'b1;
            scan_wrap  <= (state == SCAN) && wrap_pend;
            if (dwell_done) begin
                cnt       <= '0;
                ptr       <= ptr_next;
                wrap_pend <= ptr_last;
            end else begin
                cnt       <= cnt + CW'(1);
                wrap_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chan_mux_scan.sv
// tb/tb_chan_mux_scan.sv - scoreboard bench for chan_mux_scan, 4-channel and 3-channel builds
module tb_chan_mux_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [11:0] din3;
    logic [1:0]  sel;
    logic        mode;
    logic        en;

    logic [3:0]  dout0, dout1;
    logic [1:0]  ch0, ch1;
    logic        v0, v1, w0, w1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chan_mux_scan #(.WIDTH(4), .NCH(4), .SELW(2), .DWELL(4)) u_dut (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
        .dout(dout0), .dout_ch(ch0), .dout_valid(v0), .scan_wrap(w0)
    );

    chan_mux_scan #(.WIDTH(4), .NCH(3), .SELW(2), .DWELL(1)) u_dut3 (
        .clk(clk), .rst(rst), .din(din3), .sel(sel), .mode(mode), .en(en),
        .dout(dout1), .dout_ch(ch1), .dout_valid(v1), .scan_wrap(w1)
    );

    typedef struct {
        logic [3:0] d;
        logic [1:0] c;
        logic       v;
        logic       w;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference: scan position is a count of scan edges since the scan started
    // from channel 'last'; channel = (last + idx/DWELL) mod NCH.
    int         last[2];
    int         idx[2];
    logic [3:0] hold_d[2];
    logic [1:0] hold_c[2];

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            last[u] = 0; idx[u] = 0; hold_d[u] = '0; hold_c[u] = '0;
        end
    endfunction

    function automatic exp_t model(input int u, input int n, input int dw, input logic [15:0] dd);
        exp_t e;
        int   ch;
        if (!en) begin
            e.d = hold_d[u]; e.c = hold_c[u]; e.v = 1'b0; e.w = 1'b0;
            return e;
        end
        if (!mode) begin
            if (idx[u] > 0) last[u] = (last[u] + idx[u] / dw) % n;
            idx[u] = 0;
            e.c = sel;
            e.w = 1'b0;
            if (int'(sel) < n) begin
                last[u] = int'(sel);
                e.d = dd[sel*4 +: 4];
                e.v = 1'b1;
            end else begin
                e.d = '0;
                e.v = 1'b0;
            end
        end else begin
            ch  = (last[u] + idx[u] / dw) % n;
            e.c = ch[1:0];
            e.d = dd[ch*4 +: 4];
            e.v = 1'b1;
            e.w = (idx[u] >= dw) && (idx[u] % dw == 0) && (ch == 0);
            idx[u]++;
        end
        hold_d[u] = e.d;
        hold_c[u] = e.c;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a registered sample every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("n4_dout", 32'(dout0), 32'(e.d));
                chk("n4_ch", 32'(ch0), 32'(e.c));
                chk("n4_valid", 32'(v0), 32'(e.v));
                chk("n4_wrap", 32'(w0), 32'(e.w));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("n3_dout", 32'(dout1), 32'(e.d));
                chk("n3_ch", 32'(ch1), 32'(e.c));
                chk("n3_valid", 32'(v1), 32'(e.v));
                chk("n3_wrap", 32'(w1), 32'(e.w));
            end
        end
    end

    task automatic cyc(input logic e, input logic m, input logic [1:0] s, input logic rand_din);
        en = e; mode = m; sel = s;
        if (rand_din) begin
            din  = 16'($urandom);
            din3 = 12'($urandom);
        end
        @(posedge clk);
        q0.push_back(model(0, 4, 4, din));
        q1.push_back(model(1, 3, 1, {4'h0, din3}));
        #1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_dout", 32'(dout0), 32'h0);
        chk("rst_ch", 32'(ch0), 32'h0);
        chk("rst_valid", 32'(v0), 32'h0);
        chk("rst_valid3", 32'(v1), 32'h0);
        model_reset();
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic m;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0;
        din = 16'($urandom); din3 = 12'($urandom);
        model_reset();
        #12 rst = 1'b0;
        @(posedge clk);
        #1;

        repeat (2) cyc(1'b0, 1'b1, 2'd0, 1'b1);

        din = 16'hDCBA;
        for (int s = 0; s < 4; s++) cyc(1'b1, 1'b0, 2'(s), 1'b0);

        mid_reset();
        repeat (10) cyc(1'b1, 1'b1, 2'd0, 1'b1);
        repeat (5)  cyc(1'b0, 1'b1, 2'd0, 1'b1);
        repeat (14) cyc(1'b1, 1'b1, 2'd0, 1'b1);

        cyc(1'b1, 1'b0, 2'd2, 1'b1);
        repeat (6) cyc(1'b1, 1'b1, 2'd0, 1'b1);
        cyc(1'b1, 1'b0, 2'd1, 1'b1);
        cyc(1'b1, 1'b0, 2'd3, 1'b1);
        repeat (7) cyc(1'b1, 1'b1, 2'd3, 1'b1);

        m = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) m = ~m;
            if (i == 200) mid_reset();
            cyc(($urandom_range(0, 7) != 0), m, 2'($urandom), 1'b1);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q0.size() + q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chan_mux_scan.md
Name: chan_mux_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Two modes:
  - Direct: an external select picks the channel.
  - Auto-scan: an internal pointer steps round-robin through the channels, holding each one for a programmable dwell time.
- Sits between multi-source data (RAM/ROM read ports, BCD digit lanes) and a single consumer, e.g. a display scanner or serial readout.
- Generalises the 4x1 mux: width, channel count and scan FSM are added.

Parameters:
WIDTH, 4, data bits per channel (1..32)
NCH, 4, number of input channels (2..16, need not be a power of 2)
SELW, 2, select/pointer width; must satisfy 2**SELW >= NCH
DWELL, 4, cycles each channel is held in scan mode (1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
din  input  NCH*WIDTH  flattened channel data; channel k = din[k*WIDTH +: WIDTH]
sel  input  SELW  channel select, used in direct mode
mode  input  1  0 = direct, 1 = auto-scan
en  input  1  1 = operate; 0 = freeze
dout  output  WIDTH  registered selected data
dout_ch  output  SELW  index of the channel currently on dout
dout_valid  output  1  1 = dout/dout_ch hold a valid sample this cycle
scan_wrap  output  1  one-cycle pulse when the scan pointer wraps NCH-1 -> 0

Behaviour:
- Reset (async, rst=1):
  - dout=0, dout_ch=0, dout_valid=0, scan_wrap=0.
  - Pointer=0, dwell counter=0, state=IDLE.
  - Asserting reset mid-scan or mid-dwell aborts immediately.
  - First active edge after release behaves as from IDLE.
- All outputs are registered. Latency is 1 clk from the input change (din/sel/mode/en) to the output.
- States: IDLE, DIRECT, SCAN.
  - IDLE: en=1 & mode=0 -> DIRECT; en=1 & mode=1 -> SCAN.
  - DIRECT <-> SCAN follows mode on any edge with en=1.
  - Any state with en=0: state, pointer and counter hold.
- en=0: dout and dout_ch hold, dout_valid=0, scan_wrap=0.
- DIRECT:
  - sel<NCH: dout<=din[sel], dout_ch<=sel, dout_valid<=1.
  - sel>=NCH (non-power-of-2 NCH): dout<=0, dout_ch<=sel, dout_valid<=0.
  - The pointer tracks sel (pointer<=sel when sel<NCH). The dwell counter is held at 0.
- SCAN:
  - Each en=1 cycle: dout<=din[pointer], dout_ch<=pointer, dout_valid<=1. dout follows live din of the current channel every cycle.
  - Dwell counter increments each en=1 cycle.
  - When counter==DWELL-1: counter<=0, pointer<=pointer+1, wrapping from NCH-1 to 0.
  - On the wrap, scan_wrap=1 on the same edge dout_ch changes to 0; otherwise 0.
  - DWELL=1: the pointer advances every cycle.
- DIRECT->SCAN: scan starts at the current pointer (last valid sel) with counter=0. The first scanned channel is held a full DWELL cycles.
- SCAN->DIRECT: the next edge outputs din[sel]. The counter clears, and there is no scan_wrap on that edge.
- mode toggling while en=0: takes effect on the first edge with en=1.
- Pointer arithmetic: SELW bits, with explicit compare against NCH-1. The pointer never holds a value >=NCH.
- Mux selection: index shift on the flattened bus, combinational before the output register. No latches.

Test Plan:
- Reset/defaults: WIDTH=4, NCH=4, DWELL=4. Drive rst=1 mid-operation -> all outputs 0 immediately (async). Release rst with en=0 -> outputs remain 0.
- Direct mode, 1-cycle latency:
  - Stimulus: din channels = 4'hA, 4'hB, 4'hC, 4'hD; mode=0, en=1; sel=0,1,2,3 on successive cycles.
  - Required: one cycle later dout = A, B, C, D, dout_ch = 0..3, dout_valid=1 throughout.
- Scan dwell and wrap:
  - Stimulus: mode=1, en=1 from reset.
  - Required: dout_ch = 0 for 4 cycles, then 1, 2, 3 for 4 cycles each, then 0.
  - scan_wrap=1 for exactly the single cycle where dout_ch returns 0; 0 otherwise.
- Freeze:
  - Stimulus: during scan, dout_ch=2 after 2 dwell cycles; drop en for 5 cycles.
  - Required: dout/dout_ch hold, dout_valid=0, scan_wrap=0.
  - On en=1, channel 2 completes its remaining 2 cycles, then dout_ch=3.
- Mode switches:
  - Stimulus: DIRECT with sel=2 -> set mode=1. Required: dout_ch=2 for a full DWELL then 3.
  - Stimulus: mid-dwell, set mode=0 with sel=1. Required: next-cycle dout=din[1], scan_wrap=0.
- Non-power-of-2 NCH:
  - Configuration: NCH=3, SELW=2, DWELL=1.
  - Scan: dout_ch sequence 0,1,2,0,1,2.
  - Direct with sel=3: dout=0, dout_valid=0.
